// File: rtl/dcp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcp_pkg
// Description : Shared types and constants for the DCP target responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dcp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dcp_state_e;

    // Kind of transfer currently being served; selects bus_oe and auto-increment.
    typedef enum logic [1:0] {
        CYC_ADDR  = 2'd0,
        CYC_WRITE = 2'd1,
        CYC_READ  = 2'd2,
        CYC_PROTO = 2'd3
    } dcp_cycle_e;

    localparam logic c_RD = 1'b1;
    localparam logic c_WR = 1'b0;

    localparam int c_TIMEOUT_DEFAULT = 15;

endpackage
`default_nettype wire

// File: rtl/dcp_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module      : dcp_strobe_sync
// Description : Registers one active-low strobe and flags its falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module dcp_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic strobe_n_i,
    output logic level_o,
    output logic fall_o
);

    logic sync_q;
    logic prev_q;
    logic armed_q;

    // armed_q blocks the edge a strobe held low through reset would otherwise fake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= strobe_n_i;
            prev_q  <= sync_q;
            armed_q <= armed_q | strobe_n_i;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = armed_q & prev_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/dcp_target.sv
`default_nettype none
// ============================================================================
// Module      : dcp_target
// Description : DCP strobe-protocol target: address latch, local read/write
//               with ack or timeout, ready/error handshake back to the CPU.
//               Optional macro DCP_TARGET_AUTOINC_EN: post-increment lcl_addr
//               after every data cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dcp_target
    import dcp_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mas_n,
    input  logic          mds_n,
    input  logic          rd,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    output logic          rdy,
    output logic          err,
    output logic [AW-1:0] lcl_addr,
    output logic [DW-1:0] lcl_wdata,
    output logic          lcl_wr,
    output logic          lcl_rd,
    input  logic [DW-1:0] lcl_rdata,
    input  logic          lcl_ack
);

    localparam logic [7:0] c_TIMEOUT_CNT = 8'(TIMEOUT);

    logic mas_lvl, mas_fall;
    logic mds_lvl, mds_fall;

    dcp_strobe_sync u_mas_sync (
        .clk        (clk),
        .rst        (reset),
        .strobe_n_i (mas_n),
        .level_o    (mas_lvl),
        .fall_o     (mas_fall)
    );

    dcp_strobe_sync u_mds_sync (
        .clk        (clk),
        .rst        (reset),
        .strobe_n_i (mds_n),
        .level_o    (mds_lvl),
        .fall_o     (mds_fall)
    );

    dcp_state_e    state_q, state_d;
    dcp_cycle_e    kind_q, kind_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          rd_q;
    logic [DW-1:0] bus_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] out_q, out_d;
    logic          err_q, err_d;
    logic          lwr_q, lwr_d;
    logic          lrd_q, lrd_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            kind_q  <= CYC_ADDR;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            bus_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            lwr_q   <= 1'b0;
            lrd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd;
            bus_q   <= bus_in;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            out_q   <= out_d;
            err_q   <= err_d;
            lwr_q   <= lwr_d;
            lrd_q   <= lrd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        out_d   = out_q;
        err_d   = err_q;
        lwr_d   = 1'b0;
        lrd_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mas_fall && mds_fall) begin
                    kind_d  = CYC_PROTO;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (mas_fall) begin
                    kind_d  = CYC_ADDR;
                    addr_d  = bus_q[AW-1:0];
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (mds_fall) begin
                    kind_d  = (rd_q == c_RD) ? CYC_READ : CYC_WRITE;
                    wdata_d = bus_q;
                    lrd_d   = (rd_q == c_RD);
                    lwr_d   = (rd_q == c_WR);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // An ack on the final counted cycle still wins over the timeout.
                if (lcl_ack) begin
                    if (kind_q == CYC_READ) begin
                        out_d = lcl_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == c_TIMEOUT_CNT) begin
                    out_d   = '1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (mas_lvl && mds_lvl) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
`ifdef DCP_TARGET_AUTOINC_EN
                    if (kind_q == CYC_READ || kind_q == CYC_WRITE) begin
                        addr_d = addr_q + AW'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rdy       = (state_q == ST_DONE);
    assign bus_oe    = (state_q == ST_DONE) && (kind_q == CYC_READ);
    assign err       = err_q;
    assign bus_out   = out_q;
    assign lcl_addr  = addr_q;
    assign lcl_wdata = wdata_q;
    assign lcl_wr    = lwr_q;
    assign lcl_rd    = lrd_q;

endmodule
`default_nettype wire

// File: tb/tb_dcp_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcp_target
// Description : Self-checking bench for dcp_target; transaction-level timing
//               model plus a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcp_target;

    localparam int TIMEOUT = 15;
    localparam int K_ADDR  = 0;
    localparam int K_WR    = 1;
    localparam int K_RD    = 2;
    localparam int K_COL   = 3;
`ifdef DCP_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       mas_n, mds_n, rd;
    logic [7:0] bus_in, bus_out;
    logic       bus_oe, rdy, err;
    logic [7:0] lcl_addr, lcl_wdata, lcl_rdata;
    logic       lcl_wr, lcl_rd, lcl_ack;

    dcp_target #(.AW(8), .DW(8), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .mas_n     (mas_n),
        .mds_n     (mds_n),
        .rd        (rd),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .rdy       (rdy),
        .err       (err),
        .lcl_addr  (lcl_addr),
        .lcl_wdata (lcl_wdata),
        .lcl_wr    (lcl_wr),
        .lcl_rd    (lcl_rd),
        .lcl_rdata (lcl_rdata),
        .lcl_ack   (lcl_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;

    logic       exp_rdy = 1'b0, exp_err = 1'b0, exp_oe = 1'b0;
    logic       exp_lrd = 1'b0, exp_lwr = 1'b0;
    logic [7:0] exp_addr = '0, exp_wdata = '0, exp_out = '0;

    logic [7:0] m_addr = '0, m_wdata = '0, m_out = '0;
    logic [7:0] mem [256];

    int         obs_rdy_k, obs_req_k;
    logic       obs_err, obs_oe, obs_wr;
    logic [7:0] obs_out, obs_addr, obs_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdy",       {31'd0, rdy},    {31'd0, exp_rdy});
            check("err",       {31'd0, err},    {31'd0, exp_err});
            check("bus_oe",    {31'd0, bus_oe}, {31'd0, exp_oe});
            check("lcl_rd",    {31'd0, lcl_rd}, {31'd0, exp_lrd});
            check("lcl_wr",    {31'd0, lcl_wr}, {31'd0, exp_lwr});
            check("lcl_addr",  {24'd0, lcl_addr},  {24'd0, exp_addr});
            check("lcl_wdata", {24'd0, lcl_wdata}, {24'd0, exp_wdata});
            check("bus_out",   {24'd0, bus_out},   {24'd0, exp_out});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_addr  = '0; m_wdata = '0; m_out = '0;
        exp_rdy = 1'b0; exp_err = 1'b0; exp_oe = 1'b0;
        exp_lrd = 1'b0; exp_lwr = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_out = '0;
    endtask

    // Step k = interval after the k-th rising edge; strobe falls at the pin in step 0.
    // Timing: request/address response at step 2, rdy one step after ack sampling,
    // timeout rdy at step 3+TIMEOUT, rdy drops at max(rdy_step+1, release_step+2).
    task automatic xfer(input int kind, input logic [7:0] data, input int ack_d,
                        input int rel, input int gap, input int abort_k);
        bit is_data, to, ack_now;
        int e, x;
        is_data = (kind == K_WR) || (kind == K_RD);
        to      = is_data && (ack_d < 0 || ack_d > TIMEOUT);
        e       = !is_data ? 2 : (to ? 3 + TIMEOUT : 3 + ack_d);
        x       = (e + 1 > rel + 2) ? e + 1 : rel + 2;
        obs_rdy_k = -1;
        obs_req_k = -1;
        for (int k = 0; k < x + gap; k++) begin
            tick();
            if (obs_rdy_k < 0 && rdy === 1'b1) begin
                obs_rdy_k = k; obs_err = err; obs_out = bus_out; obs_oe = bus_oe;
            end
            if (obs_req_k < 0 && (lcl_rd === 1'b1 || lcl_wr === 1'b1)) begin
                obs_req_k = k; obs_addr = lcl_addr; obs_wdata = lcl_wdata; obs_wr = lcl_wr;
            end
            if (k == abort_k) begin
                reset   = 1'b1;
                lcl_ack = 1'b0;
                model_reset();
                return;
            end
            if (k == 2) begin
                if (kind == K_ADDR) m_addr = data;
                else if (is_data)   m_wdata = data;
            end
            if (k == e && is_data) begin
                if (to)                m_out = 8'hFF;
                else if (kind == K_RD) m_out = mem[m_addr];
                else                   mem[m_addr] = m_wdata;
            end
            if (k == x && is_data && AUTOINC) m_addr = m_addr + 8'd1;

            exp_rdy   = (k >= e) && (k < x);
            exp_err   = exp_rdy && (kind == K_COL || to);
            exp_oe    = exp_rdy && (kind == K_RD);
            exp_lrd   = (kind == K_RD) && (k == 2);
            exp_lwr   = (kind == K_WR) && (k == 2);
            exp_addr  = m_addr;
            exp_wdata = m_wdata;
            exp_out   = m_out;

            mas_n  = !((kind == K_ADDR || kind == K_COL) && k < rel);
            mds_n  = !((kind != K_ADDR) && k < rel);
            bus_in = (k == 0) ? data : 8'($urandom);
            rd     = (k == 0) ? (kind == K_RD) : 1'($urandom);
            ack_now = is_data && !to && (k == 2 + ack_d);
            if (ack_now) begin
                lcl_ack   = 1'b1;
                lcl_rdata = mem[m_addr];
            end else begin
                lcl_ack   = (k < 2 || k >= e) ? 1'($urandom) : 1'b0;
                lcl_rdata = 8'($urandom);
            end
        end
        lcl_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, kind, ackd;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        reset = 1'b1; mas_n = 1'b0; mds_n = 1'b1; rd = 1'b0;
        bus_in = 8'h77; lcl_ack = 1'b0; lcl_rdata = 8'h00;
        model_reset();
        repeat (2) tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("reset_hold_rdy", {31'd0, rdy}, 32'd0);
        end
        check("reset_hold_addr", {24'd0, lcl_addr}, 32'd0);
        mas_n = 1'b1;
        repeat (3) tick();

        xfer(K_ADDR, 8'h5A, 0, 4, 2, -1);
        check("addr_rdy_lat", obs_rdy_k, 2);
        check("addr_err", {31'd0, obs_err}, 32'd0);
        check("addr_noreq", obs_req_k, -1);
        check("addr_val", {24'd0, lcl_addr}, 32'h5A);

        xfer(K_WR, 8'hC3, 0, 3, 2, -1);
        check("wr_req_lat", obs_req_k, 2);
        check("wr_kind", {31'd0, obs_wr}, 32'd1);
        check("wr_wdata", {24'd0, obs_wdata}, 32'hC3);
        check("wr_rdy_lat", obs_rdy_k, 3);

        xfer(K_ADDR, 8'h5A, 0, 2, 1, -1);
        xfer(K_RD, 8'h00, 3, 8, 2, -1);
        check("rd_rdy_lat", obs_rdy_k, 6);
        check("rd_data", {24'd0, obs_out}, 32'hC3);
        check("rd_oe", {31'd0, obs_oe}, 32'd1);

        xfer(K_RD, 8'h00, -1, 4, 2, -1);
        check("to_lat", obs_rdy_k - obs_req_k, 16);
        check("to_err", {31'd0, obs_err}, 32'd1);
        check("to_data", {24'd0, obs_out}, 32'hFF);

        xfer(K_RD, 8'h00, TIMEOUT, 3, 2, -1);
        check("late_ack_lat", obs_rdy_k, 18);
        check("late_ack_err", {31'd0, obs_err}, 32'd0);

        xfer(K_ADDR, 8'h21, 0, 2, 1, -1);
        xfer(K_COL, 8'h99, 0, 3, 2, -1);
        check("col_err", {31'd0, obs_err}, 32'd1);
        check("col_noreq", obs_req_k, -1);
        check("col_addr", {24'd0, lcl_addr}, 32'h21);

        xfer(K_ADDR, 8'hFF, 0, 2, 1, -1);
        xfer(K_RD, 8'h00, 1, 2, 1, -1);
        xfer(K_RD, 8'h00, 1, 2, 1, -1);
        check("autoinc_addr", {24'd0, obs_addr}, AUTOINC ? 32'h00 : 32'hFF);

        xfer(K_RD, 8'h11, -1, 30, 1, 6);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_mid_rdy", {31'd0, rdy}, 32'd0);
        end
        check("rst_mid_addr", {24'd0, lcl_addr}, 32'd0);
        mds_n = 1'b1;
        repeat (3) tick();
        xfer(K_ADDR, 8'h3C, 0, 3, 2, -1);
        check("post_rst_addr", {24'd0, lcl_addr}, 32'h3C);

        for (int t = 0; t < 80; t++) begin
            r    = $urandom_range(0, 9);
            kind = (r < 3) ? K_ADDR : (r < 6) ? K_WR : (r < 9) ? K_RD : K_COL;
            ackd = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TIMEOUT + 2);
            xfer(kind, 8'($urandom), ackd, $urandom_range(1, 22), $urandom_range(1, 3), -1);
        end

        repeat (2) tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcp_target.md
# dcp_target

Target-side responder for the DCP strobe protocol. Receives the active-low address strobe (`mas_n`) and data strobe (`mds_n`) issued by the CPU-side DCP control sequencer. Latches a register address on address cycles, executes a local read or write on data cycles, and returns read data with a ready indication. Sits on the DCP side of the link, in front of its local register file.

## Interface
Parameters:
- `AW`, 8, local register address width (≤ DW)
- `DW`, 8, DCP bus data width
- `TIMEOUT`, 15, maximum WAIT cycles before forced completion (1..255)

Ports:
- `clk`  in  1  system clock; one clock domain
- `reset`  in  1  asynchronous, active-high reset
- `mas_n`  in  1  address strobe, active-low
- `mds_n`  in  1  data strobe, active-low
- `rd`  in  1  1 = read data cycle, 0 = write; sampled with the strobe
- `bus_in`  in  DW  address/write data from the CPU side
- `bus_out`  out  DW  read data
- `bus_oe`  out  1  bus_out drive enable
- `rdy`  out  1  transfer complete; held until both strobes release
- `err`  out  1  transfer error; valid while `rdy`=1
- `lcl_addr`  out  AW  current register address
- `lcl_wdata`  out  DW  write data
- `lcl_wr`  out  1  one-cycle write request
- `lcl_rd`  out  1  one-cycle read request
- `lcl_rdata`  in  DW  local read data, valid with `lcl_ack`
- `lcl_ack`  in  1  local completion

## Operation
- Input stage: `mas_n`, `mds_n`, `rd`, `bus_in` registered once. Falling edge = previous registered value 1, current 0.
- States: IDLE, WAIT, DONE.
- IDLE:
  - `mas` fall: `lcl_addr` <= registered `bus_in[AW-1:0]`, then DONE (`err`=0).
  - `mds` fall: `lcl_wdata` <= `bus_in`. Pulse `lcl_rd` (rd=1) or `lcl_wr` (rd=0) for exactly the first WAIT cycle. Clear the counter, then WAIT.
  - Both fall in the same cycle: protocol error. No local access, then DONE with `err`=1.
- WAIT:
  - Counter increments each cycle. `lcl_ack` is sampled every WAIT cycle, including the pulse cycle.
  - On ack: read cycles capture `lcl_rdata` into `bus_out`. Go to DONE with `err`=0.
  - Counter reaches TIMEOUT without ack: `bus_out` <= all ones, then DONE with `err`=1.
- DONE:
  - `rdy`=1. `bus_oe`=1 only for read data cycles.
  - When both registered strobes are 1: return to IDLE. `rdy`, `bus_oe`, `err` clear on that transition.
- Strobe released during WAIT: the access still completes via ack or timeout. DONE then lasts one cycle.
- Strobe edges arriving while in WAIT or DONE are ignored. A new transfer needs a fresh fall seen in IDLE.
- Reset, including mid-transfer:
  - State returns to IDLE.
  - All outputs 0, including `bus_out`, `lcl_addr`, `lcl_wdata`.
  - Registered strobes preset to 1, so releasing reset with a strobe held low produces no transfer.

## Timing
- Address cycle: `rdy` high 2 cycles after `mas_n` falls at the pin.
- Data cycle: `lcl_rd`/`lcl_wr` high 2 cycles after `mds_n` falls.
- `rdy`/`bus_out` valid 1 cycle after the cycle in which `lcl_ack` is sampled.
- Same-cycle ack: `rdy` 3 cycles after the strobe.
- Timeout: `rdy`+`err` TIMEOUT+1 cycles after the request pulse.
- Release: `rdy` drops 2 cycles after the last strobe rises.

## Configuration
- `DCP_TARGET_AUTOINC_EN` defined:
  - `lcl_addr` increments by 1, modulo 2^AW, on the DONE→IDLE transition of every data cycle, read or write, whether or not `err` is set.
  - Address cycles are unaffected.
- Not defined: `lcl_addr` changes only on address cycles.

## Structure
- Package `dcp_pkg`: state enum (IDLE/WAIT/DONE), read/write encoding constants, default TIMEOUT.
- Sub-module `dcp_strobe_sync`: one input register plus falling-edge detect, preset-to-1 on reset. Instantiated once per strobe.

## Test plan
- Reset: pulse `reset` with `mas_n`=0 held → all outputs 0, no `rdy` after release until `mas_n` toggles.
- Address cycle: `bus_in`=8'h5A, `mas_n` low 4 cycles → `lcl_addr`=8'h5A, `rdy` at +2, `err`=0, no `lcl_rd`/`lcl_wr`.
- Write then read: write 8'hC3 (ack same cycle) → `lcl_wr` 1 cycle with `lcl_wdata`=8'hC3. Read with ack 3 cycles later returning 8'hC3 → `bus_out`=8'hC3, `bus_oe`=1 until release.
- Timeout: read, `lcl_ack` never asserted, TIMEOUT=15 → `rdy`+`err`=1, `bus_out`=8'hFF, 16 cycles after `lcl_rd`.
- Collision: `mas_n` and `mds_n` fall in the same cycle → `rdy`+`err`=1, no local request, `lcl_addr` unchanged.
- Autoinc (macro defined): address 8'hFF, then two reads → second read at `lcl_addr`=8'h00. Macro undefined → both reads at 8'hFF.
